// File: rtl/fanout_tree_pkg.sv
// fanout_tree_pkg: shared sizing helpers for the pipelined broadcast tree.
// Stage widths double (roughly) per level until they reach N.
package fanout_tree_pkg;

    localparam int MAX_N = 64;

    function automatic int levels_f(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int stage_width_f(int n, int k);
        int d;
        if (k == 0) return 1;
        d = 1 << (levels_f(n) - k);
        return (n + d - 1) / d;
    endfunction

    // Bit offset of stage k inside the flattened all-stage data vector
    function automatic int offset_f(int n, int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) begin
            off += stage_width_f(n, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/fanout_tree_if.sv
// fanout_tree_if: input bit stream in, broadcast word stream out.
// slave is the tree side, master is the producer/consumer side.
interface fanout_tree_if #(
    parameter int N = 2
);
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] out_bits;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_bit,
        input  in_valid,
        output in_ready,
        output out_bits,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_bit,
        output in_valid,
        input  in_ready,
        input  out_bits,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fanout_tree_stage.sv
// fanout_stage: one registered tree level with its own valid flag.
// Node j copies parent node j>>1 whenever the level takes a new word.
module fanout_stage #(
    parameter int IN_W  = 1,
    parameter int OUT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:IN_W-1]  in_data,
    input  logic             in_valid,
    output logic             rdy_in,
    output logic [0:OUT_W-1] out_data,
    output logic             out_valid,
    input  logic             rdy_out
);
    logic [0:OUT_W-1] fan;
    logic [0:OUT_W-1] data_d;
    logic [0:OUT_W-1] data_q;
    logic             valid_d;
    logic             valid_q;

    for (genvar j = 0; j < OUT_W; j++) begin : g_node
        assign fan[j] = in_data[j >> 1];
    end

    // An empty level can always refill, so bubbles collapse under stall
    assign rdy_in = !valid_q || rdy_out;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (rdy_in) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = fan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
endmodule

// File: rtl/fanout_tree.sv
// fanout_tree: pipelined broadcast of one bit to N leaves.
// Each level is a valid/ready stage; ready ripples back combinationally.
module fanout_tree
    import fanout_tree_pkg::*;
#(
    parameter int N = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fanout_tree_if.slave  bus
);
    localparam int LEVELS = levels_f(N);
    localparam int TOT    = offset_f(N, LEVELS + 1);
    localparam int OUT_O  = offset_f(N, LEVELS);

    // All levels packed end to end; level 0 is the input bit itself
    logic [0:TOT-1]  data_all;
    logic [LEVELS:0] vld;
    logic [LEVELS:0] rdy;

    assign data_all[0] = bus.in_bit;
    assign vld[0]      = bus.in_valid;
    assign rdy[LEVELS] = bus.out_ready;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int IN_W  = stage_width_f(N, k - 1);
        localparam int OUT_W = stage_width_f(N, k);
        localparam int IN_O  = offset_f(N, k - 1);
        localparam int OUT_O_K = offset_f(N, k);

        fanout_stage #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (data_all[IN_O +: IN_W]),
            .in_valid  (vld[k-1]),
            .rdy_in    (rdy[k-1]),
            .out_data  (data_all[OUT_O_K +: OUT_W]),
            .out_valid (vld[k]),
            .rdy_out   (rdy[k])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_bits  = data_all[OUT_O +: N];
    assign bus.out_valid = vld[LEVELS];
endmodule

// File: tb/tb_fanout_tree.sv
// tb_fanout_tree: directed checks on N=5/4/8/1 trees plus a random
// stall run on N=7 with an in-order scoreboard.
module tb_fanout_tree;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fanout_tree_if #(.N(5)) if5 ();
  fanout_tree_if #(.N(4)) if4 ();
  fanout_tree_if #(.N(8)) if8 ();
  fanout_tree_if #(.N(1)) if1 ();
  fanout_tree_if #(.N(7)) if7 ();

  fanout_tree #(.N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  fanout_tree #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  fanout_tree #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  fanout_tree #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fanout_tree #(.N(7)) u7 (.clk(clk), .rst_n(rst_n), .bus(if7));

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  int  pat5 [5] = '{1, 0, 1, 1, 0};
  bit  sb [$];
  int  sent;
  int  recv;
  int  cyc;
  logic [0:6] exp7;

  initial begin
    if5.in_bit = 0; if5.in_valid = 0; if5.out_ready = 1;
    if4.in_bit = 0; if4.in_valid = 0; if4.out_ready = 1;
    if8.in_bit = 0; if8.in_valid = 0; if8.out_ready = 1;
    if1.in_bit = 0; if1.in_valid = 0; if1.out_ready = 1;
    if7.in_bit = 0; if7.in_valid = 0; if7.out_ready = 1;
    rst_n = 0;
    nxt();
    nxt();
    rst_n = 1;

    @(negedge clk);
    chk("rst5_valid", if5.out_valid, 1'b0);
    chk("rst5_bits", if5.out_bits, 5'h00);
    chk("rst5_ready", if5.in_ready, 1'b1);
    chk("rst8_valid", if8.out_valid, 1'b0);
    chk("rst1_ready", if1.in_ready, 1'b1);
    nxt();

    if5.in_bit = 1; if5.in_valid = 1;
    @(negedge clk);
    chk("n5_acc_ready", if5.in_ready, 1'b1);
    nxt();
    if5.in_valid = 0; if5.in_bit = 0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("n5_lat_early", if5.out_valid, 1'b0);
      nxt();
    end
    @(negedge clk);
    chk("n5_lat_valid", if5.out_valid, 1'b1);
    chk("n5_lat_bits", if5.out_bits, 5'h1f);
    nxt();
    @(negedge clk);
    chk("n5_lat_after", if5.out_valid, 1'b0);
    nxt();

    for (int c = 0; c < 9; c++) begin
      if5.in_valid = (c < 5);
      if5.in_bit = (c < 5) ? pat5[c][0] : 1'b0;
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        chk("n5_str_valid", if5.out_valid, 1'b1);
        chk("n5_str_bits", if5.out_bits,
            (pat5[c-3] != 0) ? 5'h1f : 5'h00);
      end else begin
        chk("n5_str_idle", if5.out_valid, 1'b0);
      end
      nxt();
    end
    if5.in_valid = 0;

    if4.out_ready = 0;
    if4.in_valid = 1; if4.in_bit = 1;
    @(negedge clk);
    chk("n4_w1_ready", if4.in_ready, 1'b1);
    nxt();
    if4.in_bit = 0;
    @(negedge clk);
    chk("n4_w2_ready", if4.in_ready, 1'b1);
    nxt();
    if4.in_bit = 1;
    @(negedge clk);
    chk("n4_w3_blocked", if4.in_ready, 1'b0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("n4_hold_ready", if4.in_ready, 1'b0);
      chk("n4_hold_valid", if4.out_valid, 1'b1);
      chk("n4_hold_bits", if4.out_bits, 4'hf);
      nxt();
    end
    if4.out_ready = 1;
    @(negedge clk);
    chk("n4_rel_ready", if4.in_ready, 1'b1);
    chk("n4_rel_bits0", if4.out_bits, 4'hf);
    nxt();
    if4.in_valid = 0; if4.in_bit = 0;
    @(negedge clk);
    chk("n4_rel_valid1", if4.out_valid, 1'b1);
    chk("n4_rel_bits1", if4.out_bits, 4'h0);
    nxt();
    @(negedge clk);
    chk("n4_rel_valid2", if4.out_valid, 1'b1);
    chk("n4_rel_bits2", if4.out_bits, 4'hf);
    nxt();
    @(negedge clk);
    chk("n4_rel_empty", if4.out_valid, 1'b0);
    nxt();

    if8.in_valid = 1; if8.in_bit = 1;
    nxt();
    nxt();
    nxt();
    rst_n = 0;
    @(negedge clk);
    chk("n8_pre_valid", if8.out_valid, 1'b1);
    chk("n8_pre_bits", if8.out_bits, 8'hff);
    nxt();
    rst_n = 1;
    if8.in_valid = 0; if8.in_bit = 0;
    @(negedge clk);
    chk("n8_rst_valid", if8.out_valid, 1'b0);
    chk("n8_rst_bits", if8.out_bits, 8'h00);
    chk("n8_rst_ready", if8.in_ready, 1'b1);
    nxt();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("n8_no_ghost", if8.out_valid, 1'b0);
      nxt();
    end

    for (int c = 0; c < 10; c++) begin
      if1.in_valid = (c < 8);
      if1.in_bit = (c < 8) ? c[0] : 1'b0;
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        chk("n1_valid", if1.out_valid, 1'b1);
        chk("n1_bit", if1.out_bits[0],
            (c - 1) % 2 == 1);
      end else begin
        chk("n1_idle", if1.out_valid, 1'b0);
      end
      nxt();
    end

    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      if7.in_valid = (sent < 1000) &&
                     ($urandom_range(0, 3) != 0);
      if7.in_bit = $urandom_range(0, 1) == 1;
      if7.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (if7.out_valid) begin
        chk("n7_uniform",
            (if7.out_bits == 7'h7f) ||
            (if7.out_bits == 7'h00),
            1'b1);
      end
      if (if7.out_valid && if7.out_ready) begin
        if (sb.size() == 0) begin
          chk("n7_extra_word", sb.size(), 1);
        end else begin
          exp7 = {7{sb[0]}};
          chk("n7_word", if7.out_bits, exp7);
          void'(sb.pop_front());
        end
        recv++;
      end
      if (if7.in_valid && if7.in_ready) begin
        sb.push_back(if7.in_bit);
        sent++;
      end
      nxt();
      cyc++;
    end
    if7.in_valid = 0;
    chk("n7_timeout", cyc < 20000, 1'b1);
    chk("n7_recv_count", recv, 1000);
    chk("n7_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
